regbank_ctrl: RTL and testbench

Command-driven initiator for the 8-entry × 8-bit register bank. It accepts one command at a time over a valid/ready handshake and drives the bank's write port (we3/wa3/wd3) and both read ports (ra1/ra2). Supported operations are load-immediate, add, subtract and read-out; each command returns one result over a valid/ready response channel. It sits between a command source (testbench or future sequencer) and the register bank, and it enforces the bank's write-to-read latency so the command source never sees stale data.

---
 rtl/regbank_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_regbank_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_ctrl.sv
// -----------------------------------------------------------------------------
// regbank_ctrl
//
// Command-driven initiator for an 8-entry x 8-bit register bank. It takes one
// command at a time (LDI / ADD / SUB / RD) over a valid/ready handshake. It
// drives the bank write port (we3/wa3/wd3) and both read ports (ra1/ra2). It
// returns one result per command over a valid/ready response channel. After
// every write it inserts two settle cycles, so the bank's write-to-read
// latency is always covered before the response is offered.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   cmd_valid  command present               cmd_ready  command accepted (IDLE)
//   cmd_op     00 LDI, 01 ADD, 10 SUB, 11 RD
//   cmd_rd     destination register          cmd_rs1/2  source registers
//   cmd_imm    immediate for LDI
//   we3/wa3/wd3  bank write enable / address / data
//   ra1/ra2      bank read addresses         rd1/rd2    bank read data (comb.)
//   rsp_valid  response present              rsp_ready  consumer accepts
//   rsp_data   result                        rsp_flag   ADD carry / SUB borrow
// -----------------------------------------------------------------------------
module regbank_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs1,
    input  logic [2:0] cmd_rs2,
    input  logic [7:0] cmd_imm,
    output logic       we3,
    output logic [2:0] wa3,
    output logic [7:0] wd3,
    output logic [2:0] ra1,
    output logic [2:0] ra2,
    input  logic [7:0] rd1,
    input  logic [7:0] rd2,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_flag
);

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_SET1,
        S_SET2,
        S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic       live_q;              // low until the first edge after reset release
    logic [1:0] op_q, op_d;
    logic [2:0] rd_q, rd_d;
    logic [2:0] ra1_q, ra1_d;
    logic [2:0] ra2_q, ra2_d;
    logic [2:0] wa3_q, wa3_d;
    logic [7:0] wd3_q, wd3_d;
    logic [7:0] result_q, result_d;
    logic       flag_q, flag_d;

    // 9-bit arithmetic: bit 8 of the sum is the carry. Bit 8 of the
    // difference is the borrow, which is set exactly when rd1 < rd2.
    logic [8:0] sum9;
    logic [8:0] diff9;
    assign sum9  = {1'b0, rd1} + {1'b0, rd2};
    assign diff9 = {1'b0, rd1} - {1'b0, rd2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            live_q   <= 1'b0;
            op_q     <= OP_LDI;
            rd_q     <= 3'd0;
            ra1_q    <= 3'd0;
            ra2_q    <= 3'd0;
            wa3_q    <= 3'd0;
            wd3_q    <= 8'd0;
            result_q <= 8'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            op_q     <= op_d;
            rd_q     <= rd_d;
            ra1_q    <= ra1_d;
            ra2_q    <= ra2_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        ra1_d    = ra1_q;
        ra2_d    = ra2_q;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;
        result_d = result_q;
        flag_d   = flag_q;

        case (state_q)
            S_IDLE: begin
                // live_q keeps the block from accepting anything in the
                // reset-release cycle, to match the cmd_ready it shows.
                if (cmd_valid && live_q) begin
                    op_d = cmd_op;
                    rd_d = cmd_rd;
                    if (cmd_op == OP_LDI) begin
                        result_d = cmd_imm;
                        flag_d   = 1'b0;
                        wa3_d    = cmd_rd;
                        wd3_d    = cmd_imm;
                        state_d  = S_WRITE;
                    end else begin
                        ra1_d   = cmd_rs1;
                        ra2_d   = cmd_rs2;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                case (op_q)
                    OP_ADD: begin
                        result_d = sum9[7:0];
                        flag_d   = sum9[8];
                    end
                    OP_SUB: begin
                        result_d = diff9[7:0];
                        flag_d   = diff9[8];
                    end
                    default: begin
                        result_d = rd1;
                        flag_d   = 1'b0;
                    end
                endcase
                if (op_q == OP_RD) begin
                    state_d = S_RESP;
                end else begin
                    wa3_d   = rd_q;
                    wd3_d   = result_d;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_SET1;
            S_SET1:  state_d = S_SET2;
            S_SET2:  state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // These are decoded from state, so they fall the moment reset asserts.
    // Register 0 is hard-wired to zero, so a write aimed at it is suppressed.
    assign cmd_ready = live_q && (state_q == S_IDLE);
    assign we3       = (state_q == S_WRITE) && (wa3_q != 3'd0);
    assign rsp_valid = (state_q == S_RESP);

    assign wa3      = wa3_q;
    assign wd3      = wd3_q;
    assign ra1      = ra1_q;
    assign ra2      = ra2_q;
    assign rsp_data = result_q;
    assign rsp_flag = flag_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regbank_ctrl
//
// Drives regbank_ctrl with directed and random commands. A behavioural model
// (an array of register values plus plain arithmetic) predicts each response,
// its latency and the bank writes. The bench samples and drives all signals
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regbank_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs1;
    logic [2:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_flag;

    int n_cmp = 0;
    int n_err = 0;

    // Simple bank: writes land on the rising edge, register 0 reads as zero.
    logic [7:0] bank [8] = '{default: 8'h00};
    always @(posedge clk) if (we3) bank[wa3] <= wd3;
    assign rd1 = (ra1 == 3'd0) ? 8'h00 : bank[ra1];
    assign rd2 = (ra2 == 3'd0) ? 8'h00 : bank[ra2];

    // Reference register contents at the command level.
    int ref_regs [8];

    regbank_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one command, follow it to its response, hold the response for
    // 'hold' cycles with rsp_ready low, then release it.
    task automatic do_cmd(input int op, input int rd, input int rs1, input int rs2,
                          input int imm, input int hold);
        int a, b, e, f, lat, cyc, nwr, exp_wr;
        a = ref_regs[rs1];
        b = ref_regs[rs2];
        case (op)
            0: begin e = imm;             f = 0;               lat = 4; end
            1: begin e = (a + b) % 256;   f = (a + b > 255);   lat = 5; end
            2: begin e = (a - b + 256) % 256; f = (a < b);     lat = 5; end
            default: begin e = a;         f = 0;               lat = 2; end
        endcase
        exp_wr = (op != 3 && rd != 0) ? 1 : 0;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_rd    = 3'(rd);
        cmd_rs1   = 3'(rs1);
        cmd_rs2   = 3'(rs2);
        cmd_imm   = 8'(imm);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_rd    = 3'($urandom);
        cmd_imm   = 8'($urandom);

        cyc = 1;
        nwr = 0;
        while (!rsp_valid && cyc < 20) begin
            chk("cmd_ready_busy", cmd_ready, 0);
            if (we3) begin
                nwr++;
                chk("wa3", wa3, rd);
                chk("wd3", wd3, e);
            end
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("we3_pulses", nwr, exp_wr);
        chk("rsp_data", rsp_data, e);
        chk("rsp_flag", rsp_flag, f);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, e);
            chk("hold_flag", rsp_flag, f);
            chk("hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);

        if (op != 3 && rd != 0) ref_regs[rd] = e;
        $display("cmd op=%0d rd=%0d rs1=%0d rs2=%0d imm=%02h -> data=%02h flag=%0d lat=%0d hold=%0d",
                 op, rd, rs1, rs2, imm, rsp_data, rsp_flag, cyc, hold);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_rd    = 3'd0;
        cmd_rs1   = 3'd0;
        cmd_rs2   = 3'd0;
        cmd_imm   = 8'd0;
        rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_we3", we3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_ra1", ra1, 0);
        chk("rst_ra2", ra2, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_flag", rsp_flag, 0);
        rst = 1'b1;
        #1 chk("rel_cmd_ready_pre", cmd_ready, 0);
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);

        // Load and read back.
        do_cmd(0, 3, 0, 0, 8'h5A, 0);
        do_cmd(3, 0, 3, 0, 0, 0);
        // Add with carry.
        do_cmd(0, 1, 0, 0, 8'hF0, 0);
        do_cmd(0, 2, 0, 0, 8'h20, 0);
        do_cmd(1, 4, 1, 2, 0, 0);
        do_cmd(3, 0, 4, 0, 0, 0);
        // Subtract with and without borrow.
        do_cmd(0, 1, 0, 0, 8'h10, 0);
        do_cmd(2, 5, 1, 2, 0, 0);
        do_cmd(2, 6, 2, 1, 0, 0);
        // Register 0 is never written.
        do_cmd(0, 0, 0, 0, 8'hFF, 0);
        do_cmd(3, 0, 0, 0, 0, 0);
        // Back-pressure.
        do_cmd(0, 7, 0, 0, 8'hC3, 3);
        do_cmd(1, 7, 7, 5, 0, 2);

        // Asynchronous reset during the WRITE cycle of an ADD.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_rd    = 3'd4;
        cmd_rs1   = 3'd1;
        cmd_rs2   = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_we3_write", we3, 1);
        rst = 1'b0;
        #1;
        chk("mid_we3", we3, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_cmd_ready", cmd_ready, 0);
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) cyc++;
        end
        chk("mid_no_rsp", cyc, 0);
        rst = 1'b1;
        #1 chk("mid_rel_ready_pre", cmd_ready, 0);
        @(negedge clk);
        chk("mid_rel_ready", cmd_ready, 1);
        do_cmd(0, 2, 0, 0, 8'h33, 0);
        do_cmd(3, 0, 2, 0, 0, 0);
        do_cmd(3, 0, 4, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
